slow_clk_monitor: RTL

- Consumer-side companion to the board clock divider.
- Samples a divided/slow clock (slow_clk) in the fast clk domain and produces single-cycle rise/fall enable ticks, so game logic can run on clk with enables instead of on a derived clock.
- Measures the slow clock's period in clk cycles, declares lock once that period is stable, and flags loss of the slow clock.

---
 rtl/slow_clk_monitor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/slow_clk_monitor.sv
// rtl/slow_clk_monitor.sv - slow clock edge-tick generator, period meter and lock/loss monitor
//
// Samples slow_clk in the clk domain and turns its edges into one-cycle
// enables, measures its rise-to-rise period, declares lock on a stable
// period and flags loss when no rise arrives within TIMEOUT cycles.
//
// Ports:
//   clk          fast system clock, all state on its rising edge
//   reset        synchronous active-high reset
//   slow_clk     asynchronous divided clock under observation
//   rise_tick    one-cycle pulse per slow_clk rising edge
//   fall_tick    one-cycle pulse per slow_clk falling edge
//   period       last rise-to-rise interval in clk cycles
//   period_valid period holds a measurement since last reset/loss
//   locked       period has been stable for LOCK_COUNT matches
//   clk_lost     slow_clk has stopped
//   edge_count   wrapping count of rising edges
module slow_clk_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_clk,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             clk_lost,
    output logic [CNT_W-1:0] edge_count
);

    localparam int MW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        LOCKED     = 2'd2,
        LOST       = 2'd3
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [CNT_W-1:0]       gap_q;
    logic [CNT_W-1:0]       gap_d;
    logic [CNT_W-1:0]       period_q;
    logic [CNT_W-1:0]       edge_count_q;
    logic [MW-1:0]          match_cnt_q;
    logic                   rise_tick_q;
    logic                   fall_tick_q;
    logic                   period_valid_q;
    logic                   locked_q;
    logic                   clk_lost_q;

    logic sync_last;
    logic rise;
    logic fall;
    logic timeout;
    logic same_period;

    assign sync_last   = sync_q[SYNC_STAGES-1];
    assign rise        = sync_last & ~hist_q;
    assign fall        = ~sync_last & hist_q;
    // A rise in the same cycle always takes priority over the timeout.
    assign timeout     = (gap_q >= CNT_W'(TIMEOUT)) && !rise;
    assign same_period = (gap_q == period_q);

    // Gap restarts at 1 on a rise so that on the next rise it equals the
    // number of clk cycles between the two rises; saturates instead of wrapping.
    always_comb begin
        gap_d = gap_q;
        if (rise) begin
            gap_d = CNT_W'(1);
        end else if (gap_q != {CNT_W{1'b1}}) begin
            gap_d = gap_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= WAIT_FIRST;
            sync_q         <= '0;
            hist_q         <= 1'b0;
            gap_q          <= '0;
            period_q       <= '0;
            edge_count_q   <= '0;
            match_cnt_q    <= '0;
            rise_tick_q    <= 1'b0;
            fall_tick_q    <= 1'b0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            clk_lost_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            hist_q      <= sync_last;
            rise_tick_q <= rise;
            fall_tick_q <= fall;
            gap_q       <= gap_d;
            if (rise) begin
                edge_count_q <= edge_count_q + CNT_W'(1);
            end

            case (state_q)
                WAIT_FIRST: begin
                    if (rise) begin
                        state_q     <= MEASURE;
                        match_cnt_q <= '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_q       <= gap_q;
                        period_valid_q <= 1'b1;
                        // period_valid low means this capture has no predecessor.
                        if (period_valid_q && same_period) begin
                            if (match_cnt_q == MW'(LOCK_COUNT - 1)) begin
                                state_q     <= LOCKED;
                                locked_q    <= 1'b1;
                                match_cnt_q <= '0;
                            end else begin
                                match_cnt_q <= match_cnt_q + MW'(1);
                            end
                        end else begin
                            match_cnt_q <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (rise && !same_period) begin
                        period_q    <= gap_q;
                        locked_q    <= 1'b0;
                        match_cnt_q <= '0;
                        state_q     <= MEASURE;
                    end
                end
                LOST: begin
                    // The first rise after loss only re-arms measurement.
                    if (rise) begin
                        state_q     <= MEASURE;
                        clk_lost_q  <= 1'b0;
                        match_cnt_q <= '0;
                    end
                end
                default: state_q <= WAIT_FIRST;
            endcase

            if (timeout && (state_q != LOST)) begin
                state_q        <= LOST;
                clk_lost_q     <= 1'b1;
                locked_q       <= 1'b0;
                period_valid_q <= 1'b0;
                match_cnt_q    <= '0;
            end
        end
    end

    assign rise_tick    = rise_tick_q;
    assign fall_tick    = fall_tick_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign clk_lost     = clk_lost_q;
    assign edge_count   = edge_count_q;

endmodule
